// File: rtl/gestor_cubos_pkg.sv
// ---------------------------------------------------------------------------
// gestor_cubos_pkg
// Shared definitions for the falling-cube game-flow manager.
//   estado_t     : game FSM states (IDLE, JUGANDO, FIN)
//   *_DEF        : default timing/separation constants
//   ancho_de()   : number of bits needed to hold values 0..valor-1
// ---------------------------------------------------------------------------
package gestor_cubos_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        JUGANDO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    localparam int SEP_MIN_DEF      = 40;
    localparam int CICLOS_SPAWN_DEF = 55_000_000;
    localparam int SPAWNS_JUEGO_DEF = 120;

    // Ceil-log2 with a floor of one bit, usable in constant expressions.
    function automatic int ancho_de(input int valor);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < valor) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/selector_slot_libre.sv
// ---------------------------------------------------------------------------
// selector_slot_libre
// Combinational round-robin free-slot finder plus spawn separation check.
// Ports:
//   libre         in  NUM_CUBOS        slot i can take a new cube
//   ocupado       in  NUM_CUBOS        slot i is falling or reserved
//   pos_x_cubos   in  NUM_CUBOS*POS_W  x of cube i at [i*POS_W +: POS_W]
//   candidata     in  POS_W            proposed spawn x
//   rr_ptr        in  PTR_W            first slot to examine
//   hay_libre     out 1                at least one free slot exists
//   slot          out PTR_W            first free slot from rr_ptr upward
//   separacion_ok out 1                candidate far enough from all occupied
// ---------------------------------------------------------------------------
module selector_slot_libre
    import gestor_cubos_pkg::*;
#(
    parameter int NUM_CUBOS = 5,
    parameter int POS_W     = 9,
    parameter int SEP_MIN   = SEP_MIN_DEF,
    parameter int PTR_W     = 3
) (
    input  logic [NUM_CUBOS-1:0]       libre,
    input  logic [NUM_CUBOS-1:0]       ocupado,
    input  logic [NUM_CUBOS*POS_W-1:0] pos_x_cubos,
    input  logic [POS_W-1:0]           candidata,
    input  logic [PTR_W-1:0]           rr_ptr,
    output logic                       hay_libre,
    output logic [PTR_W-1:0]           slot,
    output logic                       separacion_ok
);

    localparam logic [POS_W:0] SEP_L = (POS_W+1)'(SEP_MIN);

    int             idx;
    logic [POS_W:0] dif;
    logic [POS_W:0] mag;

    // Walk the slots starting at rr_ptr, wrapping, and keep the first free one.
    always_comb begin
        hay_libre = 1'b0;
        slot      = '0;
        idx       = 0;
        for (int d = 0; d < NUM_CUBOS; d++) begin
            idx = int'(rr_ptr) + d;
            if (idx >= NUM_CUBOS) begin
                idx = idx - NUM_CUBOS;
            end
            if (!hay_libre && libre[idx]) begin
                hay_libre = 1'b1;
                slot      = PTR_W'(idx);
            end
        end
    end

    // One extra bit on the difference so its sign tells us whether to negate.
    always_comb begin
        separacion_ok = 1'b1;
        dif           = '0;
        mag           = '0;
        for (int j = 0; j < NUM_CUBOS; j++) begin
            if (ocupado[j]) begin
                dif = {1'b0, candidata} - {1'b0, pos_x_cubos[j*POS_W +: POS_W]};
                mag = dif[POS_W] ? (~dif + 1'b1) : dif;
                if (mag < SEP_L) begin
                    separacion_ok = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/gestor_cubos_n.sv
// ---------------------------------------------------------------------------
// gestor_cubos_n
// Game-flow manager for NUM_CUBOS falling-cube channels: game timing, slot
// allocation, spawn separation and saturating score accumulation.
// Optional build macro: DIFICULTAD_PROGRESIVA_EN (spawn period shrinks by
// period>>3 every 16 launches, floored at CICLOS_SPAWN>>1).
// Ports:
//   clk              in  1                    system clock
//   reset            in  1                    synchronous active-high reset
//   start            in  1                    start/restart (IDLE or FIN)
//   pos_x_aleatoria  in  POS_W                random candidate x
//   pos_x_cubos      in  NUM_CUBOS*POS_W      current x of each cube
//   cubo_activo      in  NUM_CUBOS            cube i is falling
//   puntos_cubos     in  NUM_CUBOS*PUNTOS_W   one-cycle catch points
//   lanzar           out NUM_CUBOS            one-hot launch pulse
//   pos_x_lanzar     out POS_W                x of launched cube
//   puntaje          out PUNTAJE_W            saturating score
//   pulso_punto      out 1                    score just absorbed points
//   jugando          out 1                    game running
//   fin_juego        out 1                    pulse on entry to FIN
// ---------------------------------------------------------------------------
module gestor_cubos_n
    import gestor_cubos_pkg::*;
#(
    parameter int NUM_CUBOS    = 5,
    parameter int POS_W        = 9,
    parameter int PUNTOS_W     = 2,
    parameter int PUNTAJE_W    = 10,
    parameter int SEP_MIN      = SEP_MIN_DEF,
    parameter int CICLOS_SPAWN = CICLOS_SPAWN_DEF,
    parameter int SPAWNS_JUEGO = SPAWNS_JUEGO_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [POS_W-1:0]              pos_x_aleatoria,
    input  logic [NUM_CUBOS*POS_W-1:0]    pos_x_cubos,
    input  logic [NUM_CUBOS-1:0]          cubo_activo,
    input  logic [NUM_CUBOS*PUNTOS_W-1:0] puntos_cubos,
    output logic [NUM_CUBOS-1:0]          lanzar,
    output logic [POS_W-1:0]              pos_x_lanzar,
    output logic [PUNTAJE_W-1:0]          puntaje,
    output logic                          pulso_punto,
    output logic                          jugando,
    output logic                          fin_juego
);

    localparam int CIC_W  = ancho_de(CICLOS_SPAWN + 1);
    localparam int PER_W  = ancho_de(SPAWNS_JUEGO + 1);
    localparam int PTR_W  = ancho_de(NUM_CUBOS);
    localparam int SUMA_W = PUNTAJE_W + 4;

    localparam logic [CIC_W-1:0]  PERIODO_BASE = CIC_W'(CICLOS_SPAWN);
    localparam logic [PER_W-1:0]  ULTIMO_PER   = PER_W'(SPAWNS_JUEGO - 1);
    localparam logic [PTR_W-1:0]  ULTIMO_SLOT  = PTR_W'(NUM_CUBOS - 1);
    localparam logic [SUMA_W-1:0] TOPE         = SUMA_W'((1 << PUNTAJE_W) - 1);

    estado_t estado, estado_sig;

    logic [CIC_W-1:0]     ciclo;
    logic [PER_W-1:0]     periodo;
    logic                 pendiente;
    logic [NUM_CUBOS-1:0] reservado;
    logic [PTR_W-1:0]     rr_ptr;
    logic [CIC_W-1:0]     limite;

    logic                 en_juego;
    logic                 reinicio;
    logic                 fin_periodo;
    logic                 ultimo_periodo;
    logic                 hay_libre;
    logic                 separacion_ok;
    logic                 aceptar;
    logic [PTR_W-1:0]     slot;
    logic [NUM_CUBOS-1:0] lanzar_sig;
    logic [SUMA_W-1:0]    suma;
    logic [SUMA_W-1:0]    total;
    logic [PUNTAJE_W-1:0] puntaje_sat;

    assign en_juego       = (estado == JUGANDO);
    assign jugando        = en_juego;
    assign reinicio       = start && (estado == IDLE || estado == FIN);
    // >= rather than == so a period shortened mid-count still wraps.
    assign fin_periodo    = en_juego && (ciclo >= limite - CIC_W'(1));
    assign ultimo_periodo = fin_periodo && (periodo == ULTIMO_PER);
    // No launch on the edge that enters FIN.
    assign aceptar        = en_juego && pendiente && hay_libre && separacion_ok
                            && !ultimo_periodo;
    assign lanzar_sig     = aceptar ? (NUM_CUBOS'(1) << slot) : '0;

    selector_slot_libre #(
        .NUM_CUBOS (NUM_CUBOS),
        .POS_W     (POS_W),
        .SEP_MIN   (SEP_MIN),
        .PTR_W     (PTR_W)
    ) u_selector (
        .libre         (~cubo_activo & ~reservado),
        .ocupado       (cubo_activo | reservado),
        .pos_x_cubos   (pos_x_cubos),
        .candidata     (pos_x_aleatoria),
        .rr_ptr        (rr_ptr),
        .hay_libre     (hay_libre),
        .slot          (slot),
        .separacion_ok (separacion_ok)
    );

`ifdef DIFICULTAD_PROGRESIVA_EN
    localparam logic [CIC_W-1:0] PERIODO_MIN = CIC_W'(CICLOS_SPAWN >> 1);

    logic [CIC_W-1:0] periodo_ef;
    logic [CIC_W-1:0] periodo_red;
    logic [3:0]       cuenta_lanz;

    always_comb begin
        periodo_red = periodo_ef - (periodo_ef >> 3);
        if (periodo_red < PERIODO_MIN) begin
            periodo_red = PERIODO_MIN;
        end
    end

    // The 4-bit counter rolls over every 16 launches, which is when we speed up.
    always_ff @(posedge clk) begin
        if (reset) begin
            periodo_ef  <= PERIODO_BASE;
            cuenta_lanz <= '0;
        end else if (reinicio) begin
            periodo_ef  <= PERIODO_BASE;
            cuenta_lanz <= '0;
        end else if (aceptar) begin
            cuenta_lanz <= cuenta_lanz + 4'd1;
            if (cuenta_lanz == 4'd15) begin
                periodo_ef <= periodo_red;
            end
        end
    end

    assign limite = periodo_ef;
`else
    assign limite = PERIODO_BASE;
`endif

    always_comb begin
        suma = '0;
        for (int i = 0; i < NUM_CUBOS; i++) begin
            suma = suma + SUMA_W'(puntos_cubos[i*PUNTOS_W +: PUNTOS_W]);
        end
    end

    assign total       = SUMA_W'(puntaje) + suma;
    assign puntaje_sat = (total > TOPE) ? TOPE[PUNTAJE_W-1:0] : total[PUNTAJE_W-1:0];

    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if (start)          estado_sig = JUGANDO;
            JUGANDO: if (ultimo_periodo) estado_sig = FIN;
            FIN:     if (start)          estado_sig = JUGANDO;
            default: estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= IDLE;
            ciclo        <= '0;
            periodo      <= '0;
            pendiente    <= 1'b0;
            reservado    <= '0;
            rr_ptr       <= '0;
            lanzar       <= '0;
            pos_x_lanzar <= '0;
            puntaje      <= '0;
            pulso_punto  <= 1'b0;
            fin_juego    <= 1'b0;
        end else begin
            estado       <= estado_sig;
            fin_juego    <= ultimo_periodo;
            lanzar       <= lanzar_sig;
            pos_x_lanzar <= aceptar ? pos_x_aleatoria : '0;
            pulso_punto  <= 1'b0;

            // A reservation lasts until the cube reports itself as falling.
            reservado <= (reservado & ~cubo_activo) | lanzar_sig;

            if (aceptar) begin
                rr_ptr <= (slot == ULTIMO_SLOT) ? '0 : slot + PTR_W'(1);
            end

            if (reinicio) begin
                ciclo   <= '0;
                periodo <= '0;
            end else if (en_juego) begin
                if (fin_periodo) begin
                    ciclo   <= '0;
                    periodo <= periodo + PER_W'(1);
                end else begin
                    ciclo <= ciclo + CIC_W'(1);
                end
            end

            // A wrap re-arms the request even if the previous one never launched.
            if (!en_juego || ultimo_periodo) begin
                pendiente <= 1'b0;
            end else if (fin_periodo) begin
                pendiente <= 1'b1;
            end else if (aceptar) begin
                pendiente <= 1'b0;
            end

            // Restart clears the score even if a catch lands on the same edge.
            if (reinicio) begin
                puntaje <= '0;
            end else if (estado != IDLE && suma != '0) begin
                puntaje     <= puntaje_sat;
                pulso_punto <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gestor_cubos_n.sv
// ---------------------------------------------------------------------------
// tb_gestor_cubos_n
// Self-checking bench for gestor_cubos_n with a small game configuration
// (3 cubes, 8-cycle periods, 4 periods per game). Directed game scenarios are
// followed by a randomized phase; every cycle is compared against a
// rule-level reference model.
// ---------------------------------------------------------------------------
module tb_gestor_cubos_n;

    localparam int N      = 3;
    localparam int POS_W  = 9;
    localparam int CIC    = 8;
    localparam int SPW    = 4;
    localparam int SEP    = 40;
    localparam int SC_MAX = 1023;

    logic          clk;
    logic          reset;
    logic          start;
    logic [8:0]    pos_x_aleatoria;
    logic [26:0]   pos_x_cubos;
    logic [2:0]    cubo_activo;
    logic [5:0]    puntos_cubos;
    logic [2:0]    lanzar;
    logic [8:0]    pos_x_lanzar;
    logic [9:0]    puntaje;
    logic          pulso_punto;
    logic          jugando;
    logic          fin_juego;

    int compared;
    int mismatched;

    // Reference model state, kept as plain game-level quantities.
    int m_mode;
    int m_tick;
    int m_period;
    int m_rr;
    int m_score;
    bit m_pending;
    bit m_resv [N];
    int px [N];
    int pts [N];

    int e_lanzar;
    int e_pos;
    int e_score;
    int e_pulse;
    int e_jug;
    int e_fin;

    gestor_cubos_n #(
        .NUM_CUBOS    (N),
        .POS_W        (POS_W),
        .PUNTOS_W     (2),
        .PUNTAJE_W    (10),
        .SEP_MIN      (SEP),
        .CICLOS_SPAWN (CIC),
        .SPAWNS_JUEGO (SPW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .pos_x_aleatoria (pos_x_aleatoria),
        .pos_x_cubos     (pos_x_cubos),
        .cubo_activo     (cubo_activo),
        .puntos_cubos    (puntos_cubos),
        .lanzar          (lanzar),
        .pos_x_lanzar    (pos_x_lanzar),
        .puntaje         (puntaje),
        .pulso_punto     (pulso_punto),
        .jugando         (jugando),
        .fin_juego       (fin_juego)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        compared++;
        if (obs != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Predicts the outputs after the coming edge from the current inputs.
    task automatic modelStep();
        int  sum;
        int  k;
        int  kk;
        int  diff;
        bit  found;
        bit  ok;
        bit  restart;
        bit  launched;
        bit  last;
        if (reset) begin
            m_mode = 0; m_tick = 0; m_period = 0; m_pending = 0;
            m_rr = 0; m_score = 0;
            for (int i = 0; i < N; i++) m_resv[i] = 0;
            e_lanzar = 0; e_pos = 0; e_score = 0; e_pulse = 0; e_jug = 0; e_fin = 0;
            return;
        end
        restart  = start && (m_mode != 1);
        e_lanzar = 0; e_pos = 0; e_pulse = 0; e_fin = 0;
        launched = 0;
        kk       = 0;
        last     = (m_mode == 1) && (m_tick == CIC - 1) && (m_period == SPW - 1);
        if (m_mode == 1 && m_pending && !last) begin
            found = 0;
            for (int d = 0; d < N; d++) begin
                k = (m_rr + d) % N;
                if (!found && !cubo_activo[k] && !m_resv[k]) begin
                    found = 1;
                    kk    = k;
                end
            end
            ok = 1;
            for (int j = 0; j < N; j++) begin
                if (cubo_activo[j] || m_resv[j]) begin
                    diff = int'(pos_x_aleatoria) - px[j];
                    if (diff < 0) diff = -diff;
                    if (diff < SEP) ok = 0;
                end
            end
            if (found && ok) begin
                launched = 1;
                e_lanzar = 1 << kk;
                e_pos    = int'(pos_x_aleatoria);
                m_rr     = (kk + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_resv[i] = (m_resv[i] && !cubo_activo[i]) || (launched && i == kk);
        end
        sum = 0;
        for (int i = 0; i < N; i++) sum += pts[i];
        if (restart) begin
            m_score = 0;
        end else if (m_mode != 0 && sum > 0) begin
            m_score = (m_score + sum > SC_MAX) ? SC_MAX : m_score + sum;
            e_pulse = 1;
        end
        if (restart) begin
            m_mode = 1; m_tick = 0; m_period = 0;
        end else if (m_mode == 1) begin
            if (m_tick == CIC - 1) begin
                m_tick = 0;
                m_period++;
                if (m_period == SPW) begin
                    m_mode = 2; e_fin = 1; m_pending = 0;
                end else begin
                    m_pending = 1;
                end
            end else begin
                m_tick++;
                if (launched) m_pending = 0;
            end
        end
        e_score = m_score;
        e_jug   = (m_mode == 1) ? 1 : 0;
    endtask

    task automatic applyStimulus(input bit r, input bit s, input int cand, input int act,
                                 input int p0, input int p1, input int p2,
                                 input int q0, input int q1, input int q2);
        @(negedge clk);
        reset           = r;
        start           = s;
        pos_x_aleatoria = 9'(cand);
        cubo_activo     = 3'(act);
        pos_x_cubos     = {9'(p2), 9'(p1), 9'(p0)};
        puntos_cubos    = {2'(q2), 2'(q1), 2'(q0)};
        px[0] = p0; px[1] = p1; px[2] = p2;
        pts[0] = q0; pts[1] = q1; pts[2] = q2;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("lanzar", int'(lanzar), e_lanzar);
        checkOutput("pos_x_lanzar", int'(pos_x_lanzar), e_pos);
        checkOutput("puntaje", int'(puntaje), e_score);
        checkOutput("pulso_punto", int'(pulso_punto), e_pulse);
        checkOutput("jugando", int'(jugando), e_jug);
        checkOutput("fin_juego", int'(fin_juego), e_fin);
    endtask

    initial begin
        int a;
        int q [N];
        compared = 0; mismatched = 0;
        reset = 1'b1; start = 1'b0; pos_x_aleatoria = '0; pos_x_cubos = '0;
        cubo_activo = '0; puntos_cubos = '0;
        for (int i = 0; i < N; i++) begin px[i] = 0; pts[i] = 0; m_resv[i] = 0; end
        m_mode = 0; m_tick = 0; m_period = 0; m_pending = 0; m_rr = 0; m_score = 0;

        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_puntaje", int'(puntaje), 0);
        checkOutput("reset_jugando", int'(jugando), 0);

        // Full game with idle cubes: three launches in slot order, then FIN
        for (int i = 0; i < 36; i++) begin
            applyStimulus(0, i == 0, 100, 0, 0, 0, 0, 0, 0, 0);
            if (i == 8)  checkOutput("sin_lanzar_c8", int'(lanzar), 0);
            if (i == 9)  checkOutput("lanzar_001", int'(lanzar), 1);
            if (i == 9)  checkOutput("pos_100", int'(pos_x_lanzar), 100);
            if (i == 17) checkOutput("lanzar_010", int'(lanzar), 2);
            if (i == 25) checkOutput("lanzar_100", int'(lanzar), 4);
            if (i == 32) checkOutput("fin_pulso", int'(fin_juego), 1);
            if (i == 32) checkOutput("fin_jugando", int'(jugando), 0);
            if (i == 33) checkOutput("fin_una_vez", int'(fin_juego), 0);
        end

        // Catch in FIN, then accumulate to saturation
        applyStimulus(0, 0, 100, 0, 0, 0, 0, 1, 3, 2);
        checkOutput("suma_6", int'(puntaje), 6);
        checkOutput("pulso_6", int'(pulso_punto), 1);
        for (int i = 0; i < 169; i++) applyStimulus(0, 0, 100, 0, 0, 0, 0, 1, 3, 2);
        checkOutput("puntaje_1020", int'(puntaje), 1020);
        applyStimulus(0, 0, 100, 0, 0, 0, 0, 1, 3, 2);
        checkOutput("saturado_1023", int'(puntaje), 1023);
        applyStimulus(0, 1, 100, 0, 0, 0, 0, 1, 3, 2);
        checkOutput("restart_limpia", int'(puntaje), 0);
        checkOutput("restart_sin_pulso", int'(pulso_punto), 0);

        // Separation reject/accept, busy slots, reset while pending
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 28; i++) begin
            if (i < 10)
                applyStimulus(0, i == 0, 90, 1, 120, 0, 0, 0, 0, 0);
            else if (i < 12)
                applyStimulus(0, 0, 200, 1, 120, 0, 0, 0, 0, 0);
            else if (i < 26)
                applyStimulus(0, 0, 300, 7, 120, 200, 400, 0, 0, 0);
            else if (i == 26)
                applyStimulus(1, 0, 300, 0, 0, 0, 0, 1, 1, 1);
            else
                applyStimulus(0, 0, 300, 0, 0, 0, 0, 0, 0, 0);
            if (i == 9)  checkOutput("rechazo_sep", int'(lanzar), 0);
            if (i == 10) checkOutput("acepta_010", int'(lanzar), 2);
            if (i == 10) checkOutput("acepta_pos200", int'(pos_x_lanzar), 200);
            if (i >= 17 && i <= 25) checkOutput("ocupados", int'(lanzar), 0);
            if (i == 26) checkOutput("reset_lanzar", int'(lanzar), 0);
            if (i == 26) checkOutput("reset_score", int'(puntaje), 0);
            if (i == 26) checkOutput("reset_pulso", int'(pulso_punto), 0);
            if (i == 27) checkOutput("idle_tras_reset", int'(jugando), 0);
        end

        // Randomized play
        for (int c = 0; c < 1500; c++) begin
            a = 0;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) a = a | (1 << k);
                q[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0,
                          int'($urandom_range(0, 511)), a,
                          int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                          int'($urandom_range(0, 511)), q[0], q[1], q[2]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
